// File: rtl/mac_dot_seq_pkg.sv
// Shared types and default widths for the dot-product MAC job sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_dot_seq_pkg;

  localparam int LEN_W_DEF  = 16;
  localparam int DATA_W_DEF = 128;
  localparam int ACC_W_DEF  = 512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Bundles command, operand, MAC and result channels of the dot-product sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on cmd, op and res channels; MAC side is enable-only.
interface mac_dot_seq_if
  import mac_dot_seq_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;

  // Environment side: command/operand source, MAC instance and result consumer.
  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  cmd_ready, op_ready, mac_en, mac_a, mac_b, res_valid, res_data, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    output cmd_ready, op_ready, mac_en, mac_a, mac_b, res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_dot_seq_cla512.sv
// Carry-lookahead adder: 4-bit lookahead groups, group carries chained between groups.
// Latency: combinational.
// Backpressure: none.
module mac_dot_seq_cla512 #(
  parameter int W = 512
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s
);

  localparam int NG = W / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         cg;

  assign g = a & b;
  assign p = a ^ b;

  // Per-bit carries from lookahead inside each group; group carry-out feeds the next group.
  always_comb begin
    c  = '0;
    cg = ci;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = cg;
      c[4*k+1] = g[4*k] | (p[4*k] & cg);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
      cg       = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cg);
    end
  end

  assign s = p ^ c;

endmodule

// File: rtl/mac_dot_seq.sv
// Sequences one dot-product job into a never-cleared MAC and returns acc_end - acc_start.
// Latency: result valid N+2 edges after command acceptance (1 edge for N=0).
// Backpressure: op_valid bubbles stall the MAC; result held until res_ready, no new command meanwhile.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_dot_seq_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  base_q;
  logic [ACC_W-1:0]  res_data_q;
  logic              res_valid_q;
  logic [ACC_W-1:0]  diff;
  logic              cmd_hs;
  logic              op_hs;
  logic              last_hs;

  logic              cmd_ready_c;
  logic              op_ready_c;
  logic              mac_en_c;
  logic [DATA_W-1:0] mac_a_c;
  logic [DATA_W-1:0] mac_b_c;
  logic              busy_c;

  assign cmd_hs  = (state == IDLE) && bus.cmd_valid;
  assign op_hs   = (state == RUN) && bus.op_valid;
  assign last_hs = op_hs && (cnt_q == (len_q - LEN_W'(1)));

  // Result is the accumulator delta: mac_acc + ~base + 1, wrapping mod 2^ACC_W.
  mac_dot_seq_cla512 #(.W(ACC_W)) u_sub (
    .a  (bus.mac_acc),
    .b  (~base_q),
    .ci (1'b1),
    .s  (diff)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = (bus.cmd_len != '0) ? RUN : CAPTURE;
      RUN:     if (last_hs) state_nxt = DRAIN;
      DRAIN:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and MAC drive; MAC inputs are zero unless an operand is actually consumed.
  always_comb begin
    cmd_ready_c = 1'b0;
    op_ready_c  = 1'b0;
    mac_en_c    = 1'b0;
    mac_a_c     = '0;
    mac_b_c     = '0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        busy_c      = 1'b0;
      end
      RUN: begin
        op_ready_c = 1'b1;
        mac_en_c   = bus.op_valid;
        if (bus.op_valid) begin
          mac_a_c = bus.op_a;
          mac_b_c = bus.op_b;
        end
      end
      // Zero operands flush the last product and leave the MAC input registers at 0.
      DRAIN:   mac_en_c = 1'b1;
      default: ;
    endcase
  end

  // Job bookkeeping and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        len_q  <= bus.cmd_len;
        cnt_q  <= '0;
        base_q <= bus.mac_acc;
      end
      if (op_hs) cnt_q <= cnt_q + LEN_W'(1);
      if (state == CAPTURE) begin
        res_data_q  <= diff;
        res_valid_q <= 1'b1;
      end
      if ((state == RESP) && bus.res_ready) res_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.op_ready  = op_ready_c;
  assign bus.mac_en    = mac_en_c;
  assign bus.mac_a     = mac_a_c;
  assign bus.mac_b     = mac_b_c;
  assign bus.busy      = busy_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural MAC sharing rst_n.
// Latency: n/a.
// Backpressure: res_ready driven per scenario.
module tb_mac_dot_seq;
  import mac_dot_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_dot_seq_if bus ();

  mac_dot_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural MAC: registered inputs, accumulator adds the previously loaded product.
  logic [127:0] ma_r, mb_r;
  logic [511:0] acc;
  logic         acc_ld = 1'b0;
  logic [511:0] acc_ld_val = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_r <= '0;
      mb_r <= '0;
      acc  <= '0;
    end else if (acc_ld) begin
      acc <= acc_ld_val;
    end else if (bus.mac_en) begin
      acc  <= acc + ({384'b0, ma_r} * {384'b0, mb_r});
      ma_r <= bus.mac_a;
      mb_r <= bus.mac_b;
    end
  end
  assign bus.mac_acc = acc;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mac_en) en_cnt <= en_cnt + 1;

  int vecs = 0;
  int errs = 0;
  int t_cmd, t_last, t_res, e0;
  logic [127:0] va [8];
  logic [127:0] vb [8];

  task automatic issue_cmd(input logic [15:0] len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    t_cmd = cyc;
  endtask

  task automatic feed_ops(input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && i > 0) begin
        bus.op_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        @(negedge clk);
      end
      bus.op_valid = 1'b1;
      bus.op_a = va[i];
      bus.op_b = vb[i];
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    t_last = cyc;
  endtask

  task automatic wait_res();
    for (int k = 0; k < 40 && !bus.res_valid; k++) @(negedge clk);
    t_res = bus.res_valid ? cyc : -1;
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    vecs++; if (bus.op_ready !== 1'b0) begin errs++; $display("FAIL rst_op_ready got=%b exp=0", bus.op_ready); end
    vecs++; if (bus.mac_en !== 1'b0) begin errs++; $display("FAIL rst_mac_en got=%b exp=0", bus.mac_en); end
    vecs++; if (bus.mac_a !== 128'd0 || bus.mac_b !== 128'd0) begin errs++; $display("FAIL rst_mac_ab got=%h/%h exp=0", bus.mac_a, bus.mac_b); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
    vecs++; if (bus.res_data !== 512'd0) begin errs++; $display("FAIL rst_res_data got=%h exp=0", bus.res_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
    e0 = en_cnt;
    issue_cmd(16'd3);
    vecs++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL basic_busy got=%b/%b exp=1/0", bus.busy, bus.cmd_ready); end
    feed_ops(3, 1'b0);
    wait_res();
    vecs++; if (t_res - t_cmd !== 5) begin errs++; $display("FAIL basic_latency got=%0d exp=5", t_res - t_cmd); end
    vecs++; if (bus.res_data !== 512'd68) begin errs++; $display("FAIL basic_res_data got=%0d exp=68", bus.res_data); end
    vecs++; if (acc !== 512'd68) begin errs++; $display("FAIL basic_mac_acc got=%0d exp=68", acc); end
    vecs++; if (ma_r !== 128'd0 || mb_r !== 128'd0) begin errs++; $display("FAIL basic_mac_inregs got=%h/%h exp=0", ma_r, mb_r); end
    vecs++; if (en_cnt - e0 !== 4) begin errs++; $display("FAIL basic_en_count got=%0d exp=4", en_cnt - e0); end
    take_res();
    vecs++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL basic_release got=%b/%b exp=0/1", bus.res_valid, bus.cmd_ready); end
  endtask

  task automatic test_second_job();
    va[0] = 10; vb[0] = 10; va[1] = 1; vb[1] = 1;
    issue_cmd(16'd2);
    feed_ops(2, 1'b0);
    wait_res();
    vecs++; if (bus.res_data !== 512'd101) begin errs++; $display("FAIL second_res_data got=%0d exp=101", bus.res_data); end
    vecs++; if (acc !== 512'd169) begin errs++; $display("FAIL second_mac_acc got=%0d exp=169", acc); end
    take_res();
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 4; i++) begin va[i] = 1; vb[i] = 1; end
    e0 = en_cnt;
    issue_cmd(16'd4);
    feed_ops(4, 1'b1);
    wait_res();
    vecs++; if (t_res - t_last !== 2) begin errs++; $display("FAIL bubble_latency got=%0d exp=2", t_res - t_last); end
    vecs++; if (en_cnt - e0 !== 5) begin errs++; $display("FAIL bubble_en_count got=%0d exp=5", en_cnt - e0); end
    vecs++; if (bus.res_data !== 512'd4) begin errs++; $display("FAIL bubble_res_data got=%0d exp=4", bus.res_data); end
    take_res();
  endtask

  task automatic test_zero_len();
    e0 = en_cnt;
    bus.op_valid = 1'b1;
    bus.op_a = 128'd5;
    bus.op_b = 128'd5;
    issue_cmd(16'd0);
    vecs++; if (bus.mac_a !== 128'd0 || bus.op_ready !== 1'b0) begin errs++; $display("FAIL zero_op_ignored got=%h/%b exp=0/0", bus.mac_a, bus.op_ready); end
    wait_res();
    vecs++; if (t_res - t_cmd !== 1) begin errs++; $display("FAIL zero_latency got=%0d exp=1", t_res - t_cmd); end
    vecs++; if (bus.res_data !== 512'd0) begin errs++; $display("FAIL zero_res_data got=%0d exp=0", bus.res_data); end
    vecs++; if (en_cnt - e0 !== 0) begin errs++; $display("FAIL zero_en_count got=%0d exp=0", en_cnt - e0); end
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    // A command offered while the result waits must not be taken.
    bus.cmd_valid = 1'b1;
    bus.cmd_len = 16'd7;
    repeat (2) @(negedge clk);
    #1;
    vecs++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL zero_cmd_ignored got=%b%b%b exp=110", bus.busy, bus.res_valid, bus.cmd_ready); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    vecs++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL zero_no_same_cycle_cmd got=%b/%b exp=0/1", bus.busy, bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    bus.cmd_len = '0;
  endtask

  task automatic test_max_values();
    logic [511:0] one, x, pre;
    one = 512'd1;
    x   = (one << 256) - (one << 129) + one;
    pre = 512'd0 - 512'd100;
    va[0] = '1; vb[0] = '1;
    issue_cmd(16'd1);
    feed_ops(1, 1'b0);
    wait_res();
    vecs++; if (bus.res_data !== x) begin errs++; $display("FAIL max_res_data got=%h exp=%h", bus.res_data, x); end
    take_res();
    // Park the accumulator just below 2^512 so the job's sum wraps.
    @(negedge clk);
    acc_ld_val = pre;
    acc_ld = 1'b1;
    @(negedge clk);
    acc_ld = 1'b0;
    issue_cmd(16'd1);
    feed_ops(1, 1'b0);
    wait_res();
    vecs++; if (bus.res_data !== x) begin errs++; $display("FAIL wrap_res_data got=%h exp=%h", bus.res_data, x); end
    vecs++; if (acc !== pre + x) begin errs++; $display("FAIL wrap_mac_acc got=%h exp=%h", acc, pre + x); end
    take_res();
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < 5; i++) begin va[i] = 7; vb[i] = 7; end
    issue_cmd(16'd5);
    feed_ops(2, 1'b0);
    rst_n = 1'b0;
    #1;
    vecs++; if (bus.busy !== 1'b0 || bus.mac_en !== 1'b0 || bus.op_ready !== 1'b0) begin errs++; $display("FAIL midrst_outputs got=%b%b%b exp=000", bus.busy, bus.mac_en, bus.op_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL midrst_no_result got=%b exp=0", bus.res_valid); end
    end
    vecs++; if (acc !== 512'd0) begin errs++; $display("FAIL midrst_mac_acc got=%0d exp=0", acc); end
    va[0] = 3; vb[0] = 3;
    issue_cmd(16'd1);
    feed_ops(1, 1'b0);
    wait_res();
    vecs++; if (bus.res_data !== 512'd9) begin errs++; $display("FAIL midrst_res_data got=%0d exp=9", bus.res_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++; if (bus.res_valid !== 1'b1 || bus.res_data !== 512'd9) begin errs++; $display("FAIL hold_res got=%b/%0d exp=1/9", bus.res_valid, bus.res_data); end
    end
    take_res();
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL hold_release got=%b exp=0", bus.res_valid); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_second_job();
    test_bubbles();
    test_zero_len();
    test_max_values();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Job sequencer for the 512-bit CLA multiply-accumulate datapath (128x128 operands, registered inputs, free-running accumulator with no clear).
- Accepts a dot-product command of length N, streams N operand pairs into the MAC, and issues one zero-operand drain cycle.
- Returns the job's result as the accumulator delta `acc_end - acc_start` (mod 2^512), so the MAC never needs clearing.
- Sits between the command/operand source and the MAC instance; shares `rst_n` with that MAC.

Parameters:
- LEN_W, 16, width of the command length field (max N = 2^LEN_W - 1)
- DATA_W, 128, operand width; must match the MAC input width
- ACC_W, 512, accumulator/result width; must match the MAC output width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; also drives the MAC's rst_n
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  LEN_W  number of operand pairs N
- op_valid  in  1  operand pair offered
- op_ready  out  1  high only in RUN
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- mac_en  out  1  MAC enable (combinational)
- mac_a  out  DATA_W  MAC A_in (combinational)
- mac_b  out  DATA_W  MAC B_in (combinational)
- mac_acc  in  ACC_W  MAC acc_out
- res_valid  out  1  result held valid
- res_ready  in  1  result consumer ready
- res_data  out  ACC_W  job result (registered)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, base=0, res_data=0, res_valid=0.
  - Combinational outputs while in reset: cmd_ready=1, op_ready=0, mac_en=0, mac_a=0, mac_b=0, busy=0.
- MAC timing model:
  - An mac_en=1 edge loads A_in/B_in and adds the previously loaded product to acc.
  - mac_en=0 freezes the MAC completely.
- MAC invariant: the MAC input registers hold 0 whenever state is IDLE. This holds after reset and is restored by DRAIN.
- Zero outputs: mac_a and mac_b are 0 in every cycle where they are not driving a consumed operand.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch len=cmd_len, cnt=0, base=mac_acc.
  - Go to RUN if cmd_len≠0, else to CAPTURE.
- RUN:
  - op_ready=1; mac_en=op_valid; mac_a/mac_b=op_a/op_b when op_valid, else 0.
  - Each handshake increments cnt.
  - The handshake with cnt==len-1 moves to DRAIN.
  - Bubbles (op_valid=0) stall with no effect on the MAC.
- DRAIN (exactly 1 cycle): mac_en=1, mac_a=mac_b=0. Flushes the last product into acc and zeroes the MAC input registers. Next state CAPTURE.
- CAPTURE (1 cycle): res_data <= mac_acc - base (ACC_W wrap-around, no saturation); res_valid <= 1; next state RESP.
- RESP:
  - res_valid=1 and res_data held stable until res_ready=1.
  - On handshake: res_valid=0, go to IDLE.
  - No new command is accepted in the same cycle.
- Latency: command accepted at edge T, N back-to-back operands, res_valid rises at edge T+N+2. For N=0, res_valid rises at T+1 with res_data=0.
- Overflow: the product sum wraps mod 2^ACC_W; no flag.
- Reset mid-job: controller and MAC return to their reset state together. The partial job is discarded; no res_valid is produced.
- Ignored inputs:
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - op_valid outside RUN is ignored (op_ready=0).

Decomposition:
- Shared package holds:
  - state enum IDLE/RUN/DRAIN/CAPTURE/RESP
  - DATA_W/ACC_W/LEN_W defaults
- Sub-module: the 512-bit subtractor is an instance of the existing CLA512 adder, with B=~base and Ci=1. No other sub-module.

Test Plan:
- Reset then N=3 pairs (2,3),(4,5),(6,7), back-to-back -> res_data=68 at edge T+5. MAC acc=68 and MAC input registers=0 afterwards.
- Second job without reset, N=2 pairs (10,10),(1,1) -> res_data=101, not 169. mac_acc=169.
- N=4 pairs (1,1) each, with op_valid low every other cycle -> mac_en low on bubbles; res_data=4; res_valid 2 cycles after the 4th handshake.
- N=0 -> res_valid one cycle after command acceptance with res_data=0; mac_en never asserted.
- Max values: N=1, A=B=2^128-1 -> res_data=2^256-2^129+1. Also preload base with acc near 2^512 to confirm the subtraction wraps and res_data is still correct.
- rst_n low during RUN after 2 of 5 pairs, then N=1 pair (3,3) -> no result for the aborted job; res_data=9; res_ready held low for 5 cycles keeps res_data stable.
